// File: rtl/stack_controller_if.sv
// Handshake and memory-side signal bundle between the control unit, register bank,
// data memory and the stack sequencer.
interface stack_controller_if;
    logic        push_req;
    logic        pop_req;
    logic [31:0] push_data;
    logic [31:0] rp_atual;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] rp_novo;
    logic        PilhaE;
    logic        pop_wr;
    logic [31:0] pop_data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        underflow;

    modport slave (
        input  push_req, pop_req, push_data, rp_atual, mem_rdata,
        output mem_addr, mem_wdata, mem_write, mem_read, rp_novo, PilhaE,
               pop_wr, pop_data, busy, done, overflow, underflow
    );

    modport master (
        output push_req, pop_req, push_data, rp_atual, mem_rdata,
        input  mem_addr, mem_wdata, mem_write, mem_read, rp_novo, PilhaE,
               pop_wr, pop_data, busy, done, overflow, underflow
    );
endinterface

// File: rtl/stack_controller.sv
// Push/pop sequencer for the full-descending stack addressed by $rp: issues the
// data-memory access, computes the new $rp and strobes the register bank.
module stack_controller #(
    parameter logic [31:0] STACK_BASE  = 32'd224,
    parameter logic [31:0] STACK_LIMIT = 32'd192
) (
    input  logic               clock,
    input  logic               reset,
    stack_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH   = 3'd1,
        POP_RD = 3'd2,
        POP_WB = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rp_q, rp_d;
    logic [31:0] data_q, data_d;
    logic        ovf_q, ovf_d;     // error cause: 1 = overflow, 0 = underflow

    logic [31:0] mem_addr, mem_wdata, rp_novo, pop_data;
    logic        mem_write, mem_read, pilha_e, pop_wr, busy, done, overflow, underflow;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    // NOTE: only the small control registers need a reset; there is no storage array here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rp_q    <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rp_d      = rp_q;
        data_d    = data_q;
        ovf_d     = ovf_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        rp_novo   = '0;
        pilha_e   = 1'b0;
        pop_wr    = 1'b0;
        pop_data  = '0;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Push wins a tie; the losing pop is simply dropped.
                if (bus.push_req) begin
                    rp_d   = bus.rp_atual;
                    data_d = bus.push_data;
                    if (bus.rp_atual <= STACK_LIMIT) begin
                        ovf_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        state_d = PUSH;
                    end
                end else if (bus.pop_req) begin
                    rp_d = bus.rp_atual;
                    if (bus.rp_atual >= STACK_BASE) begin
                        ovf_d   = 1'b0;
                        state_d = ERR;
                    end else begin
                        state_d = POP_RD;
                    end
                end
            end
            PUSH: begin
                mem_write = 1'b1;
                mem_addr  = rp_q - 32'd1;
                mem_wdata = data_q;
                pilha_e   = 1'b1;
                rp_novo   = rp_q - 32'd1;
                done      = 1'b1;
                state_d   = IDLE;
            end
            POP_RD: begin
                mem_read = 1'b1;
                mem_addr = rp_q;
                state_d  = POP_WB;
            end
            POP_WB: begin
                pop_data = bus.mem_rdata;
                pop_wr   = 1'b1;
                pilha_e  = 1'b1;
                rp_novo  = rp_q + 32'd1;
                done     = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                done      = 1'b1;
                overflow  = ovf_q;
                underflow = ~ovf_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_write = mem_write;
    assign bus.mem_read  = mem_read;
    assign bus.rp_novo   = rp_novo;
    assign bus.PilhaE    = pilha_e;
    assign bus.pop_wr    = pop_wr;
    assign bus.pop_data  = pop_data;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;

endmodule
